// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcodes, FSM states and sizing constants for alu_seq_arbiter
package alu_seq_pkg;
  localparam int OPW         = 4;
  localparam int EXEC_CYCLES = 4;
  localparam int CNTW        = $clog2(EXEC_CYCLES);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;
endpackage

// File: rtl/alu_seq_rr_arb.sv
// rtl/alu_seq_rr_arb.sv - 2-way round-robin grant; pointer remembers the last winner
module alu_seq_rr_arb (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic valid0,
  input  logic valid1,
  output logic grant0,
  output logic grant1
);
  // last_q = 1 means req1 won last, so req0 takes the next tie
  logic last_q;

  always_comb begin
    grant0 = en && valid0 && (!valid1 || last_q);
    grant1 = en && valid1 && (!valid0 || !last_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (grant0 || grant1) begin
      last_q <= grant1;
    end
  end
endmodule

// File: rtl/alu_seq_arbiter.sv
// rtl/alu_seq_arbiter.sv - two-requester iterative ALU; define ALU_SEQ_DIV_EN to build the divider
module alu_seq_arbiter
  import alu_seq_pkg::*;
#(
  parameter int W = OPW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  input  logic           req1_valid,
  output logic           req0_ready,
  output logic           req1_ready,
  input  logic [2:0]     req0_op,
  input  logic [2:0]     req1_op,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  input  logic           req0_cin,
  input  logic           req1_cin,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [2*W-1:0] rsp_result,
  output logic           rsp_flag
);
  state_e state, state_nxt;

  logic grant0, grant1, accept;
  logic [2:0] op_q;
  logic [W-1:0] a_q, b_q;
  logic cin_q, id_q;
  logic [CNTW-1:0] cnt_q;

  logic [2*W-1:0] acc_q, mcand_q, acc_nxt;
  logic [W-1:0] mult_q;

  logic is_multi, exec_done;
  logic [W:0] sum, diff;
  logic [2*W-1:0] res_nxt;
  logic flag_nxt;

`ifdef ALU_SEQ_DIV_EN
  logic [W-1:0] rem_q, quo_q, rem_nxt, quo_nxt;
  logic [W:0] div_sh, div_tr;
`endif

  alu_seq_rr_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .en     (state == IDLE && !rst),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  assign accept = grant0 || grant1;

  always_comb begin
    is_multi = (op_q == OP_MUL);
`ifdef ALU_SEQ_DIV_EN
    is_multi = is_multi || (op_q == OP_DIV && b_q != '0);
`endif
    exec_done = !is_multi || (cnt_q == CNTW'(EXEC_CYCLES - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    if (exec_done) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = grant0;
    req1_ready = grant1;
    rsp_valid  = (state == RESP);
  end

  // Shift-add multiply: one multiplier bit per EXEC cycle, LSB first
  always_comb begin
    acc_nxt = mult_q[0] ? acc_q + mcand_q : acc_q;
  end

`ifdef ALU_SEQ_DIV_EN
  // Restoring divide: dividend bits enter MSB first, remainder stays below b
  always_comb begin
    div_sh  = {rem_q, quo_q[W-1]};
    div_tr  = div_sh - {1'b0, b_q};
    rem_nxt = div_tr[W] ? div_sh[W-1:0] : div_tr[W-1:0];
    quo_nxt = {quo_q[W-2:0], ~div_tr[W]};
  end
`endif

  always_comb begin
    sum      = (W+1)'(a_q) + (W+1)'(b_q) + (W+1)'(cin_q);
    diff     = (W+1)'(a_q) - (W+1)'(b_q) - (W+1)'(cin_q);
    res_nxt  = '0;
    flag_nxt = 1'b0;
    case (op_q)
      OP_ADD: begin
        res_nxt[W-1:0] = sum[W-1:0];
        flag_nxt       = sum[W];
      end
      OP_SUB: begin
        res_nxt[W-1:0] = diff[W-1:0];
        flag_nxt       = diff[W];
      end
      OP_MUL: res_nxt = acc_nxt;
`ifdef ALU_SEQ_DIV_EN
      OP_DIV: begin
        if (b_q == '0) begin
          res_nxt  = {a_q, {W{1'b1}}};
          flag_nxt = 1'b1;
        end else begin
          res_nxt = {rem_nxt, quo_nxt};
        end
      end
`endif
      default: flag_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      id_q       <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mult_q     <= '0;
      rsp_result <= '0;
      rsp_flag   <= 1'b0;
      rsp_id     <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      rem_q      <= '0;
      quo_q      <= '0;
`endif
    end else if (accept) begin
      op_q    <= grant1 ? req1_op : req0_op;
      a_q     <= grant1 ? req1_a : req0_a;
      b_q     <= grant1 ? req1_b : req0_b;
      cin_q   <= grant1 ? req1_cin : req0_cin;
      id_q    <= grant1;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= (2*W)'(grant1 ? req1_a : req0_a);
      mult_q  <= grant1 ? req1_b : req0_b;
`ifdef ALU_SEQ_DIV_EN
      rem_q   <= '0;
      quo_q   <= grant1 ? req1_a : req0_a;
`endif
    end else if (state == EXEC) begin
      cnt_q   <= cnt_q + 1'b1;
      acc_q   <= acc_nxt;
      mcand_q <= mcand_q << 1;
      mult_q  <= mult_q >> 1;
`ifdef ALU_SEQ_DIV_EN
      rem_q   <= rem_nxt;
      quo_q   <= quo_nxt;
`endif
      if (exec_done) begin
        rsp_result <= res_nxt;
        rsp_flag   <= flag_nxt;
        rsp_id     <= id_q;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq_arbiter.sv
// tb/tb_alu_seq_arbiter.sv - directed self-checking bench for alu_seq_arbiter (honours ALU_SEQ_DIV_EN)
module tb_alu_seq_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [2:0] req0_op, req1_op;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_cin, req1_cin;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_flag;
  logic [7:0] rsp_result;

  int checks   = 0;
  int failures = 0;

  alu_seq_arbiter #(.W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .req0_op    (req0_op),
    .req1_op    (req1_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req0_cin   (req0_cin),
    .req1_cin   (req1_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flag   (rsp_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // lat = index of the first edge after the accepting edge that samples rsp_valid high
  task automatic do_op(input string tag, input bit id, input logic [2:0] op,
                       input logic [3:0] a, input logic [3:0] b, input logic cin,
                       input logic [7:0] er, input logic ef, input int el);
    int  lat;
    bit  seen;
    @(negedge clk);
    if (id) begin
      req1_op = op; req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1;
    end else begin
      req0_op = op; req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1;
    end
    #1 chk({tag, "_ready"}, id ? req1_ready : req0_ready, 1'b1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = ~a; req0_b = ~b; req1_a = ~a; req1_b = ~b;
    req0_op = op ^ 3'b001; req1_op = op ^ 3'b001;
    req0_cin = ~cin; req1_cin = ~cin;
    lat  = 0;
    seen = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1;
        lat  = k;
      end
    end
    chk({tag, "_lat"}, lat, el);
    if (seen) begin
      chk({tag, "_result"}, rsp_result, er);
      chk({tag, "_flag"}, rsp_flag, ef);
      chk({tag, "_id"}, rsp_id, id);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
    end
  endtask

  initial begin
    int  got;
    bit  seen;
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_op = 0; req1_op = 0; req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    req0_cin = 0; req1_cin = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_result", rsp_result, 8'h00);
    chk("rst_flag", rsp_flag, 1'b0);
    chk("rst_id", rsp_id, 1'b0);
    chk("rst_ready0", req0_ready, 1'b0);
    chk("rst_ready1", req1_ready, 1'b0);
    rst = 1'b0;

    do_op("add_9_8_1", 1'b0, 3'b000, 4'd9, 4'd8, 1'b1, 8'h02, 1'b1, 2);
    do_op("mul_15_15", 1'b1, 3'b010, 4'd15, 4'd15, 1'b0, 8'hE1, 1'b0, 5);
`ifdef ALU_SEQ_DIV_EN
    do_op("div_13_4", 1'b0, 3'b011, 4'd13, 4'd4, 1'b0, 8'h13, 1'b0, 5);
    do_op("div_7_0", 1'b1, 3'b011, 4'd7, 4'd0, 1'b0, 8'h7F, 1'b1, 2);
    do_op("div_15_1", 1'b0, 3'b011, 4'd15, 4'd1, 1'b0, 8'h0F, 1'b0, 5);
`else
    do_op("div_13_4", 1'b0, 3'b011, 4'd13, 4'd4, 1'b0, 8'h00, 1'b1, 2);
    do_op("div_7_0", 1'b1, 3'b011, 4'd7, 4'd0, 1'b0, 8'h00, 1'b1, 2);
`endif
    do_op("illegal", 1'b0, 3'b101, 4'd6, 4'd3, 1'b1, 8'h00, 1'b1, 2);
    do_op("sub_2_2_1", 1'b1, 3'b001, 4'd2, 4'd2, 1'b1, 8'h0F, 1'b1, 2);
    do_op("sub_9_4_1", 1'b0, 3'b001, 4'd9, 4'd4, 1'b1, 8'h04, 1'b0, 2);
    do_op("add_15_0_0", 1'b1, 3'b000, 4'd15, 4'd0, 1'b0, 8'h0F, 1'b0, 2);
    do_op("mul_7_3", 1'b0, 3'b010, 4'd7, 4'd3, 1'b0, 8'h15, 1'b0, 5);
    do_op("mul_0_9", 1'b1, 3'b010, 4'd0, 4'd9, 1'b0, 8'h00, 1'b0, 5);

    // Contending requesters straight after reset
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    req0_op = 3'b001; req0_a = 4'd3; req0_b = 4'd5; req0_cin = 1'b0;
    req1_op = 3'b001; req1_a = 4'd3; req1_b = 4'd5; req1_cin = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      seen = 0; got = 2;
      for (int k = 0; k < 10 && !seen; k++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) begin
          seen = 1;
          got  = {req1_ready, req0_ready};
        end
      end
      chk($sformatf("tie_grant%0d", i), got, (i % 2 == 0) ? 1 : 2);
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
        @(negedge clk);
        if (rsp_valid) seen = 1;
      end
      chk($sformatf("tie_rsp_seen%0d", i), seen, 1'b1);
      chk($sformatf("tie_result%0d", i), {rsp_flag, rsp_result}, 9'h10E);
      chk($sformatf("tie_id%0d", i), rsp_id, i % 2);
      chk($sformatf("tie_ready_in_resp%0d", i), {req1_ready, req0_ready}, 2'b00);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk);
    #1 rsp_ready = 1'b0;

    // Backpressure: response must hold while a new request waits
    @(negedge clk);
    req0_op = 3'b000; req0_a = 4'd1; req0_b = 4'd2; req0_cin = 1'b0; req0_valid = 1'b1;
    @(posedge clk);
    #1 req0_valid = 1'b0;
    req1_op = 3'b010; req1_a = 4'd2; req1_b = 4'd3; req1_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("stall%0d", k),
          {rsp_valid, rsp_id, rsp_result, rsp_flag, req0_ready, req1_ready},
          {1'b1, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0});
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    chk("post_hs_no_grant_same_cycle", rsp_valid, 1'b0);
    @(negedge clk);
    chk("pending_req1_granted", {req1_ready, req0_ready}, 2'b10);
    req1_valid = 1'b0;

    // Reset during MUL aborts it and restores req0 tie priority
    @(negedge clk);
    req0_op = 3'b010; req0_a = 4'd15; req0_b = 4'd15; req0_valid = 1'b1;
    @(posedge clk);
    #1 req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    chk("abort_no_rsp", seen, 1'b0);
    req0_op = 3'b000; req1_op = 3'b000;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1 chk("abort_tie_req0", {req1_ready, req0_ready}, 2'b01);
    req0_valid = 1'b0; req1_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_seq_arbiter.md
ALU_SEQ_ARBITER -- requirements
Module: alu_seq_arbiter

Interface
REQ-001 Parameter W, default 4: operand width; only W=4 is required to be supported.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0_valid, req1_valid  input  1  requester N presents an operation.
REQ-005 req0_ready, req1_ready  output  1  requester N's operation is accepted on this edge when valid is also high.
REQ-006 req0_op, req1_op  input  3  opcode: 000 ADD, 001 SUB, 010 MUL, 011 DIV; all others illegal.
REQ-007 req0_a, req0_b, req1_a, req1_b  input  4  operands.
REQ-008 req0_cin, req1_cin  input  1  carry-in for ADD, borrow-in for SUB; ignored otherwise.
REQ-009 rsp_valid  output  1  response available.
REQ-010 rsp_ready  input  1  consumer accepts the response.
REQ-011 rsp_id  output  1  index of the requester that issued the operation.
REQ-012 rsp_result  output  8  result, encoded per op.
REQ-013 rsp_flag  output  1  carry, borrow, divide-by-zero or illegal-op indicator.

Function
REQ-014 FSM states SHALL be IDLE, EXEC and RESP.
REQ-015 In IDLE, at most one reqN_ready is high: the grant of a 2-way round-robin (combinational from the valids).
  - Sole valid requester wins.
  - If both are valid, the requester not granted last wins.
REQ-016 On acceptance, operands, op, cin and the requester id SHALL be registered, the round-robin pointer SHALL be updated, and the FSM SHALL enter EXEC.
REQ-017 Both reqN_ready SHALL be low in EXEC and RESP; no new operation is accepted until the FSM returns to IDLE.
REQ-018 EXEC length: 1 cycle for ADD, SUB, illegal op and divide-by-zero; exactly 4 cycles for MUL and for DIV with b!=0.
REQ-019 rsp_valid SHALL be high 2 cycles after the accepting edge (ADD/SUB/illegal/div0) or 5 cycles after it (MUL/DIV).
REQ-020 ADD: {rsp_flag, rsp_result[3:0]} = a + b + cin (5-bit); rsp_result[7:4] = 0.
REQ-021 SUB: rsp_result[3:0] = (a - b - cin) mod 16; rsp_flag = 1 iff a < b + cin; rsp_result[7:4] = 0.
REQ-022 MUL: iterative shift-add, one multiplier bit per EXEC cycle, LSB first.
  - rsp_result = a*b (8-bit, unsigned); rsp_flag = 0.
REQ-023 DIV, b != 0: restoring division, one quotient bit per EXEC cycle, MSB first.
  - rsp_result[3:0] = a/b; rsp_result[7:4] = a%b; rsp_flag = 0.
REQ-024 DIV, b == 0: rsp_result[3:0] = 4'hF, rsp_result[7:4] = a, rsp_flag = 1.
REQ-025 Illegal op: rsp_result = 0, rsp_flag = 1.
REQ-026 In RESP, rsp_valid, rsp_id, rsp_result and rsp_flag SHALL hold stable until rsp_valid && rsp_ready; the FSM then returns to IDLE.
REQ-027 A request pending during RESP SHALL be arbitrated in the first IDLE cycle after the response handshake, never in the same cycle.
REQ-028 Outside RESP, rsp_valid SHALL be 0; rsp_result, rsp_flag and rsp_id are don't-care there.
REQ-029 Changes to reqN_* inputs after acceptance SHALL NOT affect the in-flight result.

Reset
REQ-030 While rst is high on an edge: FSM -> IDLE, rsp_valid = 0, rsp_result = 0, rsp_flag = 0, rsp_id = 0, reqN_ready low, and the round-robin pointer set so that req0 wins the first tie.
REQ-031 Reset asserted during EXEC or RESP SHALL abort the operation; no response is produced for it.

Configuration
REQ-032 Macro ALU_SEQ_DIV_EN:
  - Defined: DIV SHALL behave per REQ-023/REQ-024.
  - Undefined: opcode 011 SHALL be treated as illegal (REQ-025), and no divider logic SHALL be synthesized.

Structure
REQ-033 Package alu_seq_pkg SHALL hold the opcode enum, the FSM state enum, the operand-width constant (4) and the iterative cycle count (4).
REQ-034 The round-robin grant logic and its pointer SHALL be a sub-module named alu_seq_rr_arb.

Verification
REQ-035 req0 ADD a=9, b=8, cin=1 -> rsp_result=8'h02, rsp_flag=1, rsp_id=0, rsp_valid 2 cycles after accept.
REQ-036 req1 MUL a=15, b=15 -> rsp_result=8'hE1, rsp_flag=0, rsp_id=1, rsp_valid 5 cycles after accept.
REQ-037 DIV a=13, b=4 -> rsp_result=8'h13; DIV a=7, b=0 -> rsp_result=8'h7F, rsp_flag=1; without ALU_SEQ_DIV_EN both -> 8'h00, rsp_flag=1.
REQ-038 Both requesters valid continuously after reset with SUB a=3, b=5, cin=0 -> grants alternate 0,1,0,1; each response is 8'h0E with rsp_flag=1.
REQ-039 rsp_ready held low 10 cycles in RESP -> outputs stable, both reqN_ready low; rst pulsed mid-MUL -> rsp_valid stays 0 and the next tie grants req0.
